decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The module SHALL have parameter RSP_INIT, default 64'h0000_0000_0000_0400, giving the reset value of %rsp (register 4).
REQ-002 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  clock; all register-file writes occur on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset of the register file.
REQ-005 icode  input  4  instruction code from fetch.
REQ-006 rA  input  4  first register specifier from fetch.
REQ-007 rB  input  4  second register specifier from fetch.
REQ-008 Cnd  input  1  condition flag from execute; gates cmovXX writeback.
REQ-009 valE  input  64  execute result, written to dstE.
REQ-010 valM  input  64  memory read data, written to dstM.
REQ-011 wb_en  input  1  writeback enable; 0 suppresses all writes (halt/stall).
REQ-012 dbg_addr  input  4  debug read register index.
REQ-013 valA  output  64  operand A, read from srcA, to execute.
REQ-014 valB  output  64  operand B, read from srcB, to execute.
REQ-015 srcA, srcB, dstE, dstM  output  4 each  decoded register IDs; 4'hF = RNONE.
REQ-016 dbg_data  output  64  contents of register dbg_addr (0 for index F).

Function
REQ-017 Storage SHALL be 15 registers of 64 bits, indices 0-14; %rsp = 4; index F is not storage.
REQ-018 srcA SHALL be rA for icode 2,4,6,A; 4 for icode 9,B; F otherwise.
REQ-019 srcB SHALL be rB for icode 4,5,6; 4 for icode 8,9,A,B; F otherwise.
REQ-020 dstE SHALL be rB for icode 3,6; rB if Cnd=1 else F for icode 2; 4 for icode 8,9,A,B; F otherwise.
REQ-021 dstM SHALL be rA for icode 5,B; F otherwise.
REQ-022 icode 0,1,7 and undefined C-F SHALL give srcA=srcB=dstE=dstM=F.
REQ-023 valA, valB, dbg_data SHALL be combinational reads of current register contents, returning 0 for index F; no bypass of same-cycle writes.
REQ-024 On rising clk with rst=0 and wb_en=1: if dstE!=F, reg[dstE]<=valE; if dstM!=F, reg[dstM]<=valM.
REQ-025 If dstE==dstM!=F (popq %rsp), the register SHALL take valM.
REQ-026 An rA or rB of F reaching dstE/dstM SHALL cause no write.
REQ-027 wb_en=0 SHALL leave all registers unchanged; decode outputs still SHALL update.
REQ-028 Read latency SHALL be zero cycles; write latency one edge, visible on valA/valB immediately after the edge.

Reset
REQ-029 rst=1 SHALL immediately, independent of clk, set registers 0-3 and 5-14 to 0 and register 4 to RSP_INIT.
REQ-030 While rst=1 no write SHALL occur on any clk edge; rst asserted mid-cycle SHALL override a pending write.
REQ-031 Decode outputs SHALL remain combinational functions of icode/rA/rB/Cnd during reset.

Verification
REQ-032 Reset: pulse rst between edges -> dbg_data(4)=0x400, dbg_data(0..3,5..14)=0, valA=valB=0.
REQ-033 irmovq: icode=3, rB=2, valE=7, wb_en=1, edge -> reg2=7; then icode=6, rA=2, rB=2 -> srcA=srcB=2, valA=valB=7, dstE=2.
REQ-034 cmovXX: icode=2, rA=1, rB=3, valE=5, Cnd=0, edge -> dstE=F, reg3 unchanged; Cnd=1, edge -> reg3=5.
REQ-035 popq %rsp: icode=B, rA=4, valE=0x408, valM=0x99, edge -> srcA=srcB=4, dstE=dstM=4, rsp=0x99.
REQ-036 mrmovq/wb_en: icode=5, rA=6, rB=F, valM=0x1234, edge -> reg6=0x1234, srcB=F, valB=0; repeat valM=0x55 with wb_en=0 -> reg6 stays 0x1234.
REQ-037 Reset mid-op: reg6=0x1234, set up write, assert rst before edge -> reg6=0 at once, stays 0 across edges while rst=1.

Source files
------------

// File: rtl/decode_writeback.sv
// Y86-64 style decode / writeback stage.
// Decodes register IDs from icode/rA/rB/Cnd, reads operands combinationally
// from a 15-entry x 64-bit register file and writes valE/valM back on clk.
// Index 4'hF (RNONE) is not storage: reads return 0, writes are dropped.

// One general-purpose register with its own write-select logic.
module decode_writeback_gpr #(
    parameter logic [3:0]  IDX  = 4'd0,
    parameter logic [63:0] INIT = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [3:0]  dst_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_e,
    input  logic [63:0] val_m,
    output logic [63:0] q
);

    // valM wins when both ports target this register (popq %rsp)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= INIT;
        end else if (wb_en) begin
            if (dst_m == IDX) begin
                q <= val_m;
            end else if (dst_e == IDX) begin
                q <= val_e;
            end
        end
    end

endmodule

module decode_writeback #(
    parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        Cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] dbg_data
);

    localparam int          NUM_REGS = 15;
    localparam logic [3:0]  RNONE    = 4'hF;
    localparam logic [3:0]  RSP      = 4'h4;

    logic [NUM_REGS-1:0][63:0] regs;

    // Read port: 4'hF never matches a storage index, so it reads as 0.
    function automatic logic [63:0] rd(input logic [NUM_REGS-1:0][63:0] r,
                                       input logic [3:0] idx);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) v = r[i];
        end
        return v;
    endfunction

    // Register ID decode per instruction class; undefined icodes give RNONE.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'h2: begin                     // cmovXX
                srcA = rA;
                dstE = Cnd ? rB : RNONE;
            end
            4'h3: dstE = rB;                // irmovq
            4'h4: begin                     // rmmovq
                srcA = rA;
                srcB = rB;
            end
            4'h5: begin                     // mrmovq
                srcB = rB;
                dstM = rA;
            end
            4'h6: begin                     // OPq
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'h8: begin                     // call
                srcB = RSP;
                dstE = RSP;
            end
            4'h9: begin                     // ret
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            4'hA: begin                     // pushq
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            4'hB: begin                     // popq
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Register array; register 4 (%rsp) resets to RSP_INIT.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_gpr
        decode_writeback_gpr #(
            .IDX  (4'(g)),
            .INIT ((g == 4) ? RSP_INIT : 64'd0)
        ) u_gpr (
            .clk   (clk),
            .rst   (rst),
            .wb_en (wb_en),
            .dst_e (dstE),
            .dst_m (dstM),
            .val_e (valE),
            .val_m (valM),
            .q     (regs[g])
        );
    end

    // Zero-latency operand and debug reads, no same-cycle write bypass.
    always_comb begin
        valA     = rd(regs, srcA);
        valB     = rd(regs, srcB);
        dbg_data = rd(regs, dbg_addr);
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: driver pushes expected outputs from
// a behavioural register-file model; a negedge monitor pops and compares.
module tb_decode_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  icode = '0, rA = '0, rB = '0, dbg_addr = '0;
    logic        Cnd = 1'b0, wb_en = 1'b0;
    logic [63:0] valE = '0, valM = '0;
    logic [63:0] valA, valB, dbg_data;
    logic [3:0]  srcA, srcB, dstE, dstM;

    decode_writeback dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .Cnd(Cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en), .dbg_addr(dbg_addr),
        .valA(valA), .valB(valB), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sa, sb, de, dm;
        logic [63:0] va, vb, dbg;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] m[16];
    int          total = 0;
    int          bad = 0;
    bit          drv_done = 1'b0;

    // Model state of the currently applied stimulus (committed at next edge)
    logic [3:0]  c_ic, c_ra, c_rb;
    logic        c_cnd, c_wb, c_rst;
    logic [63:0] c_ve, c_vm;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m[i] = 64'd0;
        m[4] = 64'h400;
    endfunction

    // Register IDs straight from the instruction-class tables.
    function automatic void mdec(input logic [3:0] ic, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic c,
                                 output logic [3:0] sa, output logic [3:0] sb,
                                 output logic [3:0] de, output logic [3:0] dm);
        sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra :
             (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        de = (ic inside {4'h3, 4'h6}) ? rb :
             (ic == 4'h2) ? (c ? rb : 4'hF) :
             (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        dm = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    function automatic void model_commit();
        logic [3:0] sa, sb, de, dm;
        if (c_rst || !c_wb) return;
        mdec(c_ic, c_ra, c_rb, c_cnd, sa, sb, de, dm);
        if (de != 4'hF) m[de] = c_ve;
        if (dm != 4'hF) m[dm] = c_vm;   // valM overrides valE
    endfunction

    task automatic step(input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic c,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic wb, input logic [3:0] da, input logic r);
        exp_t e;
        @(posedge clk);
        model_commit();
        #1;
        icode = ic; rA = ra; rB = rb; Cnd = c; valE = ve; valM = vm;
        wb_en = wb; dbg_addr = da; rst = r;
        c_ic = ic; c_ra = ra; c_rb = rb; c_cnd = c; c_ve = ve; c_vm = vm;
        c_wb = wb; c_rst = r;
        if (r) model_reset();
        mdec(ic, ra, rb, c, e.sa, e.sb, e.de, e.dm);
        e.va  = (e.sa == 4'hF) ? 64'd0 : m[e.sa];
        e.vb  = (e.sb == 4'hF) ? 64'd0 : m[e.sb];
        e.dbg = (da == 4'hF) ? 64'd0 : m[da];
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, sampled at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("srcA", 64'(srcA), 64'(e.sa));
                chk("srcB", 64'(srcB), 64'(e.sb));
                chk("dstE", 64'(dstE), 64'(e.de));
                chk("dstM", 64'(dstM), 64'(e.dm));
                chk("valA", valA, e.va);
                chk("valB", valB, e.vb);
                chk("dbg_data", dbg_data, e.dbg);
            end
        end
    end

    // Driver: directed scenarios followed by random traffic
    initial begin
        int n;
        model_reset();
        c_rst = 1'b1; c_wb = 1'b0; c_ic = '0; c_ra = '0; c_rb = '0;
        c_cnd = 1'b0; c_ve = '0; c_vm = '0;

        // reset pulse, then dump every register index
        step(4'h0, 4'hF, 4'hF, 0, 0, 0, 0, 4'h4, 1);
        for (int i = 0; i < 16; i++) step(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'(i), 0);

        // irmovq then OPq reading it back
        step(4'h3, 4'hF, 4'h2, 0, 64'd7, 0, 1, 4'h2, 0);
        step(4'h6, 4'h2, 4'h2, 0, 0, 0, 0, 4'h2, 0);

        // cmovXX not taken, then taken
        step(4'h2, 4'h1, 4'h3, 0, 64'd5, 0, 1, 4'h3, 0);
        step(4'h2, 4'h1, 4'h3, 1, 64'd5, 0, 1, 4'h3, 0);
        step(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h3, 0);

        // popq %rsp: valM wins over valE
        step(4'hB, 4'h4, 4'hF, 0, 64'h408, 64'h99, 1, 4'h4, 0);
        step(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h4, 0);

        // mrmovq with rB=F, then suppressed by wb_en=0
        step(4'h5, 4'h6, 4'hF, 0, 0, 64'h1234, 1, 4'h6, 0);
        step(4'h5, 4'h6, 4'hF, 0, 0, 64'h55, 0, 4'h6, 0);
        step(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h6, 0);

        // reset asserted mid-cycle over a pending write, held across edges
        step(4'h5, 4'h6, 4'hF, 0, 0, 64'h777, 1, 4'h6, 1);
        step(4'h5, 4'h6, 4'hF, 0, 0, 64'h777, 1, 4'h6, 1);
        step(4'hB, 4'h6, 4'hF, 0, 64'h1, 64'h777, 1, 4'h6, 1);
        step(4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h6, 0);

        // random traffic, occasional reset and stall
        n = 400;
        for (int k = 0; k < n; k++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 49) == 0));
        end
        drv_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then summarise
    initial begin
        int guard;
        wait (drv_done);
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
